// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB responder: FSM states, device ID default
// and bit-counter sizing.
package sccb_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_ID       = 4'd1,
        S_ID_ACK   = 4'd2,
        S_SUB      = 4'd3,
        S_SUB_ACK  = 4'd4,
        S_DATA     = 4'd5,
        S_DATA_ACK = 4'd6,
        S_RD       = 4'd7,
        S_RD_NA    = 4'd8,
        S_IGNORE   = 4'd9
    } state_t;

    localparam logic [6:0] DEV_ID_DEFAULT = 7'h21;
    localparam int         ACK_BIT        = 8;
    localparam int         CNT_W          = 4;

    // Counter value once all 8 data bits are in, and once the 9th bit is in.
    localparam logic [CNT_W-1:0] CNT_ACK = CNT_W'(ACK_BIT);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(ACK_BIT + 1);

endpackage

// File: rtl/sccb_sync_edge.sv
// Two-flop synchronizer for an asynchronous pad input with one-cycle
// rise/fall pulses derived from the synchronized value.
module sccb_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchronizer chain plus one delay stage for edge detection; idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
            prev_r <= 1'b1;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign sync = sync_r;
    assign rise = sync_r & ~prev_r;
    assign fall = ~sync_r & prev_r;

endmodule

// File: rtl/sccb_responder.sv
// SCCB slave with a 256x8 register file: 3-phase write, 2-phase address set
// and 2-phase read, single byte per transaction.
module sccb_responder
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ID = DEV_ID_DEFAULT
) (
    input  logic       sccb_clk,
    input  logic       sccb_reset,
    input  logic       sio_c_in,
    input  logic       sio_d_in,
    output logic       sio_d_oe,
    output logic       sio_d_out,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    logic scl_s, scl_rise_s, scl_fall_s;
    logic sda_s, sda_rise_s, sda_fall_s;
    logic start_s, stop_s;

    sccb_sync_edge u_sync_c (
        .clk   (sccb_clk),
        .reset (sccb_reset),
        .din   (sio_c_in),
        .sync  (scl_s),
        .rise  (scl_rise_s),
        .fall  (scl_fall_s)
    );

    sccb_sync_edge u_sync_d (
        .clk   (sccb_clk),
        .reset (sccb_reset),
        .din   (sio_d_in),
        .sync  (sda_s),
        .rise  (sda_rise_s),
        .fall  (sda_fall_s)
    );

    assign start_s = sda_fall_s & scl_s;
    assign stop_s  = sda_rise_s & scl_s;

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [7:0]       sh_r, sh_s;
    logic [7:0]       sub_r, sub_s;
    logic             rw_r, rw_s;
    logic [6:0]       tx_r, tx_s;
    logic             oe_r, oe_s;
    logic             out_r, out_s;
    logic             busy_r, busy_s;
    logic             we_s;
    logic [7:0]       wdata_s;
    logic             wr_strobe_r;
    logic [7:0]       wr_addr_r, wr_data_r;
    logic [7:0]       rd_q_r;
    logic [7:0]       mem [256];

    assign wdata_s = {sh_r[6:0], sda_s};

    // Next-state, pad-drive and write-request logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        sh_s    = sh_r;
        sub_s   = sub_r;
        rw_s    = rw_r;
        tx_s    = tx_r;
        oe_s    = oe_r;
        out_s   = out_r;
        busy_s  = busy_r;
        we_s    = 1'b0;
        if (stop_s) begin
            state_s = S_IDLE;
            cnt_s   = '0;
            oe_s    = 1'b0;
            out_s   = 1'b1;
            busy_s  = 1'b0;
        end else if (start_s) begin
            state_s = S_ID;
            cnt_s   = '0;
            oe_s    = 1'b0;
            out_s   = 1'b1;
        end else begin
            case (state_r)
                S_ID, S_SUB, S_DATA: begin
                    if (scl_rise_s && (cnt_r < CNT_ACK)) begin
                        sh_s  = wdata_s;
                        cnt_s = cnt_r + CNT_W'(1);
                        if ((state_r == S_SUB) && (cnt_r == CNT_ACK - CNT_W'(1))) begin
                            sub_s = wdata_s;
                        end else begin
                            sub_s = sub_r;
                        end
                        we_s = (state_r == S_DATA) && (cnt_r == CNT_ACK - CNT_W'(1));
                    end else if (scl_fall_s && (cnt_r == CNT_ACK)) begin
                        oe_s  = 1'b1;
                        out_s = 1'b0;
                        if (state_r == S_SUB) begin
                            state_s = S_SUB_ACK;
                        end else if (state_r == S_DATA) begin
                            state_s = S_DATA_ACK;
                        end else if (sh_r[7:1] == DEV_ID) begin
                            state_s = S_ID_ACK;
                            rw_s    = sh_r[0];
                            busy_s  = 1'b1;
                        end else begin
                            // Foreign device: stay off the bus until START/STOP.
                            state_s = S_IGNORE;
                            oe_s    = 1'b0;
                            out_s   = 1'b1;
                            busy_s  = 1'b0;
                        end
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                S_ID_ACK, S_SUB_ACK, S_DATA_ACK, S_RD_NA: begin
                    if (scl_rise_s && (cnt_r == CNT_ACK)) begin
                        cnt_s = CNT_END;
                    end else if (scl_fall_s && (cnt_r == CNT_END)) begin
                        cnt_s = '0;
                        oe_s  = 1'b0;
                        out_s = 1'b1;
                        case (state_r)
                            S_ID_ACK: begin
                                if (rw_r) begin
                                    state_s = S_RD;
                                    oe_s    = 1'b1;
                                    out_s   = rd_q_r[7];
                                    tx_s    = rd_q_r[6:0];
                                end else begin
                                    state_s = S_SUB;
                                end
                            end
                            S_SUB_ACK: state_s = S_DATA;
                            default:   state_s = S_IGNORE;
                        endcase
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                S_RD: begin
                    if (scl_rise_s && (cnt_r < CNT_ACK)) begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end else if (scl_fall_s && (cnt_r == CNT_ACK)) begin
                        state_s = S_RD_NA;
                        oe_s    = 1'b0;
                        out_s   = 1'b1;
                    end else if (scl_fall_s && (cnt_r != '0)) begin
                        out_s = tx_r[6];
                        tx_s  = {tx_r[5:0], 1'b0};
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                S_IDLE, S_IGNORE: begin
                    oe_s = 1'b0;
                end
                default: begin
                    state_s = S_IDLE;
                    oe_s    = 1'b0;
                    out_s   = 1'b1;
                end
            endcase
        end
    end

    // Control and output registers.
    always_ff @(posedge sccb_clk) begin
        if (sccb_reset) begin
            state_r     <= S_IDLE;
            cnt_r       <= '0;
            sh_r        <= 8'h00;
            sub_r       <= 8'h00;
            rw_r        <= 1'b0;
            tx_r        <= 7'h00;
            oe_r        <= 1'b0;
            out_r       <= 1'b1;
            busy_r      <= 1'b0;
            wr_strobe_r <= 1'b0;
            wr_addr_r   <= 8'h00;
            wr_data_r   <= 8'h00;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            sh_r        <= sh_s;
            sub_r       <= sub_s;
            rw_r        <= rw_s;
            tx_r        <= tx_s;
            oe_r        <= oe_s;
            out_r       <= out_s;
            busy_r      <= busy_s;
            wr_strobe_r <= we_s;
            if (we_s) begin
                wr_addr_r <= sub_r;
                wr_data_r <= wdata_s;
            end else begin
                wr_addr_r <= wr_addr_r;
                wr_data_r <= wr_data_r;
            end
        end
    end

    // Register file: contents survive reset; a reset cycle blocks the write.
    always_ff @(posedge sccb_clk) begin
        if (we_s && !sccb_reset) begin
            mem[sub_r] <= wdata_s;
        end
        rd_q_r <= mem[sub_r];
    end

    assign sio_d_oe  = oe_r;
    assign sio_d_out = out_r;
    assign wr_strobe = wr_strobe_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_sccb_responder.sv
// Directed bench for sccb_responder: bit-banged SCCB master on a wired-AND
// data line, immediate-assertion checks against hand-computed values.
module tb_sccb_responder;
    import sccb_pkg::*;

    localparam int Q = 50;  // quarter SCCB bit period; sys clock period is 10

    logic       clk = 1'b0;
    logic       sccb_reset = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sio_d_oe, sio_d_out, wr_strobe, busy;
    logic [7:0] wr_addr, wr_data;
    logic       sda_line;

    int n_cmp = 0;
    int n_err = 0;
    int strobe_cnt = 0;
    int oe_cnt = 0;
    int busy_cnt = 0;

    always #5 clk = ~clk;

    assign sda_line = sda_m & (sio_d_oe ? sio_d_out : 1'b1);

    sccb_responder dut (
        .sccb_clk  (clk),
        .sccb_reset(sccb_reset),
        .sio_c_in  (scl_m),
        .sio_d_in  (sda_line),
        .sio_d_oe  (sio_d_oe),
        .sio_d_out (sio_d_out),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    // Cycle counters for strobe, pad drive and busy.
    always @(posedge clk) begin
        if (wr_strobe) strobe_cnt <= strobe_cnt + 1;
        if (sio_d_oe)  oe_cnt     <= oe_cnt + 1;
        if (busy)      busy_cnt   <= busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_start();
        sda_m = 1'b1; #(Q);
        scl_m = 1'b1; #(Q);
        sda_m = 1'b0; #(Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; #(Q);
        scl_m = 1'b1; #(Q);
        sda_m = 1'b1; #(Q);
        #(Q);
    endtask

    task automatic xfer_bit(input logic b, output logic l, output logic oe);
        sda_m = b;    #(Q);
        scl_m = 1'b1; #(Q);
        l  = sda_line;
        oe = sio_d_oe;
        #(Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic xfer_byte(input logic [7:0] d, output logic [7:0] rx,
                             output logic ack_l, output logic ack_oe, output logic drv_all);
        logic l, o;
        drv_all = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(d[i], l, o);
            rx[i]   = l;
            drv_all = drv_all & o;
        end
        xfer_bit(1'b1, ack_l, ack_oe);
    endtask

    task automatic send_acked(input string tag, input logic [7:0] d);
        logic [7:0] rx;
        logic al, ao, dr;
        xfer_byte(d, rx, al, ao, dr);
        check(tag, {31'd0, al}, 32'd0);
    endtask

    task automatic read_reg(input string tag, input logic [7:0] sub, input logic [7:0] exp);
        logic [7:0] rx;
        logic al, ao, dr;
        bus_start();
        send_acked({tag, "_wid"}, 8'h42);
        send_acked({tag, "_sub"}, sub);
        bus_stop();
        bus_start();
        send_acked({tag, "_rid"}, 8'h43);
        xfer_byte(8'hFF, rx, al, ao, dr);
        check({tag, "_data"}, {24'd0, rx}, {24'd0, exp});
        check({tag, "_drive"}, {31'd0, dr}, 32'd1);
        check({tag, "_na_oe"}, {31'd0, ao}, 32'd0);
        bus_stop();
    endtask

    initial begin
        int s0, o0, b0;
        logic [7:0] rx;
        logic al, ao, dr, l, o;

        repeat (3) @(posedge clk);
        #1;
        check("rst_oe",     {31'd0, sio_d_oe},  32'd0);
        check("rst_out",    {31'd0, sio_d_out}, 32'd1);
        check("rst_strobe", {31'd0, wr_strobe}, 32'd0);
        check("rst_addr",   {24'd0, wr_addr},   32'd0);
        check("rst_data",   {24'd0, wr_data},   32'd0);
        check("rst_busy",   {31'd0, busy},      32'd0);
        check("rst_state",  32'(dut.state_r),   32'(S_IDLE));
        sccb_reset = 1'b0;
        repeat (5) @(posedge clk);

        // 3-phase write 0x12 <= 0x80
        s0 = strobe_cnt;
        bus_start();
        send_acked("w1_id", 8'h42);
        send_acked("w1_sub", 8'h12);
        send_acked("w1_dat", 8'h80);
        check("w1_strobes", 32'(strobe_cnt - s0), 32'd1);
        check("w1_addr", {24'd0, wr_addr}, 32'h12);
        check("w1_data", {24'd0, wr_data}, 32'h80);
        check("w1_busy", {31'd0, busy}, 32'd1);
        bus_stop();
        repeat (10) @(posedge clk);
        #1;
        check("w1_busy_stop", {31'd0, busy}, 32'd0);

        // 2-phase address set then read back
        read_reg("r1", 8'h12, 8'h80);
        check("r1_strobes", 32'(strobe_cnt - s0), 32'd1);

        // foreign ID 0x60: responder stays silent
        o0 = oe_cnt;
        b0 = busy_cnt;
        bus_start();
        xfer_byte(8'h60, rx, al, ao, dr);
        check("f_id_nack", {31'd0, al}, 32'd1);
        xfer_byte(8'h12, rx, al, ao, dr);
        xfer_byte(8'h34, rx, al, ao, dr);
        bus_stop();
        check("f_oe", 32'(oe_cnt - o0), 32'd0);
        check("f_busy", 32'(busy_cnt - b0), 32'd0);
        check("f_strobes", 32'(strobe_cnt - s0), 32'd1);

        // extra byte after data is neither acked nor written
        bus_start();
        send_acked("w2_id", 8'h42);
        send_acked("w2_sub", 8'h12);
        send_acked("w2_dat", 8'h55);
        xfer_byte(8'hAA, rx, al, ao, dr);
        check("w2_extra_nack", {31'd0, al}, 32'd1);
        check("w2_extra_oe", {31'd0, ao}, 32'd0);
        bus_stop();
        check("w2_strobes", 32'(strobe_cnt - s0), 32'd2);
        check("w2_data", {24'd0, wr_data}, 32'h55);
        read_reg("r2", 8'h12, 8'h55);

        // repeated start after sub 0x34
        bus_start();
        send_acked("w3_id", 8'h42);
        send_acked("w3_sub", 8'h34);
        send_acked("w3_dat", 8'hC3);
        bus_stop();
        bus_start();
        send_acked("rs_wid", 8'h42);
        send_acked("rs_sub", 8'h34);
        bus_start();
        check("rs_busy_held", {31'd0, busy}, 32'd1);
        send_acked("rs_rid", 8'h43);
        xfer_byte(8'hFF, rx, al, ao, dr);
        check("rs_data", {24'd0, rx}, 32'hC3);
        check("rs_na_oe", {31'd0, ao}, 32'd0);
        bus_stop();

        // reset pulsed during read bit 3 (bits 7..4 of 0xC3 are 1,1,0,0)
        bus_start();
        send_acked("rr_wid", 8'h42);
        send_acked("rr_sub", 8'h34);
        bus_stop();
        bus_start();
        send_acked("rr_rid", 8'h43);
        xfer_bit(1'b1, l, o);
        check("rr_b7", {31'd0, l}, 32'd1);
        xfer_bit(1'b1, l, o);
        check("rr_b6", {31'd0, l}, 32'd1);
        xfer_bit(1'b1, l, o);
        check("rr_b5", {31'd0, l}, 32'd0);
        xfer_bit(1'b1, l, o);
        check("rr_b4", {31'd0, l}, 32'd0);
        sda_m = 1'b1; #(Q);
        scl_m = 1'b1; #(Q);
        check("rr_b3_oe", {31'd0, sio_d_oe}, 32'd1);
        @(negedge clk);
        sccb_reset = 1'b1;
        @(posedge clk);
        #1;
        check("rr_rst_oe", {31'd0, sio_d_oe}, 32'd0);
        check("rr_rst_state", 32'(dut.state_r), 32'(S_IDLE));
        check("rr_rst_busy", {31'd0, busy}, 32'd0);
        sccb_reset = 1'b0;
        #(Q);
        scl_m = 1'b0; #(Q);
        bus_stop();
        read_reg("r3", 8'h34, 8'hC3);
        check("final_strobes", 32'(strobe_cnt - s0), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sccb_responder.md
SCCB_RESPONDER -- requirements
Module: sccb_responder

Interface
REQ-001 The block SHALL have parameter DEV_ID, default 7'h21, meaning the 7-bit SCCB device ID it answers to (write ID 0x42, read ID 0x43).
REQ-002 The block SHALL have one clock and one reset: the clock is synchronous, and the reset is synchronous and active-high.
REQ-003 Port sccb_clk SHALL be an input, 1 bit wide: the system clock, at least 8x the SIO_C rate.
REQ-004 Port sccb_reset SHALL be an input, 1 bit wide: the synchronous, active-high reset.
REQ-005 Port sio_c_in SHALL be an input, 1 bit wide: the asynchronous SCCB clock from the master.
REQ-006 Port sio_d_in SHALL be an input, 1 bit wide: the asynchronous SCCB data pad input.
REQ-007 Port sio_d_oe SHALL be an output, 1 bit wide: when 1, the pad drives sio_d_out.
REQ-008 Port sio_d_out SHALL be an output, 1 bit wide: the SCCB data value driven by the responder.
REQ-009 Port wr_strobe SHALL be an output, 1 bit wide: a one-cycle pulse per completed register write.
REQ-010 Port wr_addr SHALL be an output, 8 bits wide: the sub-address of the last write.
REQ-011 Port wr_data SHALL be an output, 8 bits wide: the data of the last write.
REQ-012 Port busy SHALL be an output, 1 bit wide: 1 from a matching ID byte until STOP.

Function
REQ-013 sio_c_in and sio_d_in SHALL pass a 2-flop synchronizer followed by edge detection; all decisions use the synchronized values.
REQ-014 START SHALL be detected as a synchronized SIO_D fall while SIO_C is high; STOP SHALL be detected as a synchronized SIO_D rise while SIO_C is high.
REQ-015 Data bits SHALL be sampled on the synchronized SIO_C rising edge, MSB first; the responder SHALL change sio_d_out/sio_d_oe only in the cycle after a synchronized SIO_C falling edge.
REQ-016 The FSM states SHALL be IDLE, ID, ID_ACK, SUB, SUB_ACK, DATA, DATA_ACK, RD, RD_NA and IGNORE.
REQ-017 START from any state, including a repeated start, SHALL go to ID and clear the bit counter; STOP from any state SHALL go to IDLE.
REQ-018 In ID, after 8 bits, if bits[7:1]==DEV_ID the FSM SHALL go to ID_ACK; otherwise it SHALL go to IGNORE, never driving SIO_D.
REQ-019 In ID_ACK, SUB_ACK and DATA_ACK (the 9th, don't-care bit), the responder SHALL drive 0 from the falling edge after bit 8 until the next falling edge.
REQ-020 ID_ACK SHALL go to SUB if R/W=0 and to RD if R/W=1.
REQ-021 SUB SHALL latch the 8-bit sub-address, then go through SUB_ACK to DATA; a STOP after SUB_ACK is a 2-phase write (address set, no register write).
REQ-022 DATA SHALL, after 8 bits, write regfile[sub]; wr_strobe SHALL be 1 for exactly one cycle, the cycle after the 8th bit is sampled, with wr_addr/wr_data valid in that cycle and held afterwards.
REQ-023 DATA_ACK SHALL go to IGNORE: there is no auto-increment, and further bytes are neither acknowledged nor written.
REQ-024 In RD, the responder SHALL drive regfile[latched sub] MSB first, bit 7 presented after the falling edge that ends ID_ACK.
REQ-025 RD_NA SHALL release SIO_D (sio_d_oe=0) for the 9th bit, then go to IGNORE regardless of NA/ACK.
REQ-026 IGNORE SHALL hold sio_d_oe=0 until START or STOP.
REQ-027 The register file SHALL be 256x8 and single-port, with reads taking one cycle and always completing before the next falling edge.
REQ-028 busy SHALL rise the cycle ID_ACK is entered and fall the cycle STOP is detected; a repeated start SHALL not clear busy until the ID byte mismatches.

Reset
REQ-029 On sccb_reset=1, the following SHALL take effect at the next sccb_clk edge: state=IDLE, sio_d_oe=0, sio_d_out=1, wr_strobe=0, wr_addr=0, wr_data=0, busy=0, bit counter=0, latched sub=0, and synchronizer flops=1.
REQ-030 Register file contents SHALL be unaffected by reset; a reset in mid-transfer SHALL abandon the transaction without a write.
REQ-031 After reset, the FSM SHALL ignore the bus until the next START.

Structure
REQ-032 Package sccb_pkg SHALL hold the FSM state enum, the DEV_ID default, the ACK bit index (8) and the bit-counter width (4).
REQ-033 Sub-module sccb_sync_edge (2-flop sync, rise/fall pulses) SHALL be instantiated once for SIO_C and once for SIO_D.
REQ-034 The register file SHALL be inferred as RAM inside sccb_responder.

Verification
REQ-035 3-phase write 0x42/0x12/0x80 -> three ACK-low bits, one wr_strobe with wr_addr=0x12 and wr_data=0x80, busy 1->0 at STOP.
REQ-036 2-phase write 0x42/0x12, STOP, then read 0x43 -> responder drives 0x80 MSB first, sio_d_oe=0 during NA, no wr_strobe.
REQ-037 ID 0x60 followed by two bytes -> sio_d_oe stays 0 throughout, no wr_strobe, busy stays 0.
REQ-038 Write 0x42/0x12/0x55 then byte 0xAA before STOP -> one strobe with data 0x55, no ACK on 0xAA, regfile[0x12]=0x55.
REQ-039 Repeated START after sub 0x34 then 0x43 -> read returns regfile[0x34].
REQ-040 sccb_reset pulsed during RD bit 3 -> sio_d_oe=0 next cycle, state IDLE, a later read of the same address returns the unchanged value.
